// File: rtl/result_display_pkg.sv
//==============================================================================
// Module  : result_display_pkg
// Brief   : Shared types and seven-segment encodings for the result display
//           scanner: hex glyph table, blank / letter-A glyphs, selection and
//           digit-slot types.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package result_display_pkg;

  // Index of the result word currently selected for display (A0..A3).
  typedef logic [1:0] sel_t;

  // Digit slot being driven; value equals the anode bit position (0 = rightmost).
  typedef enum logic [1:0] {
    SLOT_LO  = 2'd0,   // low nibble of the captured frame
    SLOT_HI  = 2'd1,   // high nibble of the captured frame
    SLOT_SEL = 2'd2,   // selection index
    SLOT_LET = 2'd3    // fixed letter 'A'
  } slot_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK    = 7'b1111111;
  localparam logic [6:0] SEG_LETTER_A = 7'b0001000;

  // Hex glyphs 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Look up the glyph for one nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nibble);
    return SEG_HEX[i_nibble];
  endfunction

  // Active-low one-hot anode pattern for a digit slot.
  function automatic logic [3:0] slot_enable(input slot_t i_slot);
    return ~(4'b0001 << i_slot);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//==============================================================================
// Module  : btn_debounce
// Brief   : Two-flop synchronizer, level debouncer and press detector for a
//           raw push-button. Emits a single-clock pulse when the debounced
//           level rises. A button already held when reset releases produces
//           no pulse until it has been seen released.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int             CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_armed;

  // Synchronizer; resets to 'pressed' so a held button never looks like a release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Previous accepted level for edge detection; arm once the button has been seen released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_armed   <= r_armed | ~r_sync2;
    end
  end

  assign o_press = r_level & ~r_level_d & r_armed;

endmodule

`default_nettype wire

// File: rtl/result_display_scanner.sv
//==============================================================================
// Module  : result_display_scanner
// Brief   : Multiplexed 4-digit seven-segment display of one of four 8-bit
//           result words. A debounced button cycles the selection; the chosen
//           word is captured once per frame so a frame never mixes words.
//           Digits (left to right): 'A', selection index, high nibble, low
//           nibble.
// Config  : DISP_LZ_BLANK_EN - when defined, the high-nibble digit is blanked
//           (anodes all off for that slot) if the nibble is zero.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module result_display_scanner
  import result_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REFRESH_DIV     = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A0,
  input  logic [7:0] A1,
  input  logic [7:0] A2,
  input  logic [7:0] A3,
  input  logic       btn_next,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [3:0] sel_led
);

  localparam int            RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

  logic          w_next;
  logic          w_ref_wrap;
  logic [7:0]    w_word;
  logic [6:0]    w_seg;
  logic [3:0]    w_an;

  logic [RW-1:0] r_ref_cnt;
  slot_t         r_idx;
  logic [7:0]    r_frame;
  sel_t          r_sel;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_next),
    .o_press (w_next)
  );

  assign w_ref_wrap = (r_ref_cnt == REF_MAX);

  // Refresh divider and digit slot index; the slot advances each time the divider wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt <= '0;
      r_idx     <= SLOT_LO;
    end else if (w_ref_wrap) begin
      r_ref_cnt <= '0;
      r_idx     <= slot_t'(r_idx + 2'd1);
    end else begin
      r_ref_cnt <= r_ref_cnt + RW'(1);
    end
  end

  // Select the word named by the current selection.
  always_comb begin
    w_word = A0;
    case (r_sel)
      2'd1:    w_word = A1;
      2'd2:    w_word = A2;
      2'd3:    w_word = A3;
      default: w_word = A0;
    endcase
  end

  // Capture one word per frame, at the wrap from the last slot back to the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= 8'h00;
    end else if (w_ref_wrap && (r_idx == SLOT_LET)) begin
      r_frame <= w_word;
    end
  end

  // Selection advances on each press; a simultaneous capture above still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= 2'd0;
    end else if (w_next) begin
      r_sel <= r_sel + 2'd1;
    end
  end

  assign sel_led = 4'b0001 << r_sel;

  // Glyph and anode pattern for the slot currently being scanned.
  always_comb begin
    w_an  = slot_enable(r_idx);
    w_seg = SEG_BLANK;
    case (r_idx)
      SLOT_LO:  w_seg = hex_to_seg(r_frame[3:0]);
      SLOT_HI: begin
`ifdef DISP_LZ_BLANK_EN
        if (r_frame[7:4] == 4'h0) begin
          w_an  = 4'b1111;
          w_seg = SEG_BLANK;
        end else begin
          w_seg = hex_to_seg(r_frame[7:4]);
        end
`else
        w_seg = hex_to_seg(r_frame[7:4]);
`endif
      end
      SLOT_SEL: w_seg = hex_to_seg({2'b00, r_sel});
      SLOT_LET: w_seg = SEG_LETTER_A;
      default:  w_seg = SEG_BLANK;
    endcase
  end

  // Segments and anodes share one register stage so they always switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= 4'b1111;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

`default_nettype wire

// File: tb/tb_result_display_scanner.sv
//==============================================================================
// Module  : tb_result_display_scanner
// Brief   : Self-checking bench for result_display_scanner with a behavioural
//           reference model compared every clock, plus literal checks of the
//           directed scenarios. Honours DISP_LZ_BLANK_EN.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_result_display_scanner;

  localparam int DEB = 4;
  localparam int REF = 2;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] A0       = 8'h00;
  logic [7:0] A1       = 8'h00;
  logic [7:0] A2       = 8'h00;
  logic [7:0] A3       = 8'h00;
  logic       btn_next = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [3:0] sel_led;

  int n_vec = 0;
  int n_err = 0;

  result_display_scanner #(
    .DEBOUNCE_CYCLES (DEB),
    .REFRESH_DIV     (REF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A0       (A0),
    .A1       (A1),
    .A2       (A2),
    .A3       (A3),
    .btn_next (btn_next),
    .seg      (seg),
    .an       (an),
    .sel_led  (sel_led)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checks
  task automatic chk7(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7:0] word_of(input int s);
    case (s)
      0: return A0;
      1: return A1;
      2: return A2;
      default: return A3;
    endcase
  endfunction

  int         m_n;       // clock edges since reset released
  logic [7:0] m_frame;
  int         m_sel;
  logic       m_sync [$];
  logic       m_acc;
  int         m_run;     // consecutive clocks the synchronized level has disagreed
  logic       m_armed;
  logic       m_pend;    // press pulse visible during the coming clock
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic [3:0] exp_led;

  task automatic model_reset();
    m_n = 0; m_frame = 8'h00; m_sel = 0;
    m_sync = {1'b1, 1'b1};
    m_acc = 1'b0; m_run = 0; m_armed = 1'b0; m_pend = 1'b0;
    exp_seg = 7'b1111111; exp_an = 4'b1111;
  endtask

  task automatic model_step();
    int   slot;
    logic s2;
    logic rose;
    if (!rst_n) begin
      model_reset();
    end else begin
      slot = (m_n / REF) % 4;
      case (slot)
        0: begin exp_an = 4'b1110; exp_seg = glyph(m_frame[3:0]); end
        1: begin
          exp_an = 4'b1101; exp_seg = glyph(m_frame[7:4]);
`ifdef DISP_LZ_BLANK_EN
          if (m_frame[7:4] == 4'h0) begin exp_an = 4'b1111; exp_seg = 7'b1111111; end
`endif
        end
        2: begin exp_an = 4'b1011; exp_seg = glyph(4'(m_sel)); end
        default: begin exp_an = 4'b0111; exp_seg = 7'b0001000; end
      endcase
      if ((m_n % (4 * REF)) == (4 * REF - 1)) m_frame = word_of(m_sel);
      if (m_pend) m_sel = (m_sel + 1) % 4;
      s2 = m_sync.pop_front();
      m_sync.push_back(btn_next);
      rose = 1'b0;
      if (s2 != m_acc) begin
        m_run++;
        if (m_run == DEB) begin m_acc = s2; m_run = 0; rose = s2; end
      end else begin
        m_run = 0;
      end
      if (!s2) m_armed = 1'b1;
      m_pend = rose && m_armed;
      m_n++;
    end
    case (m_sel)
      0: exp_led = 4'b0001;
      1: exp_led = 4'b0010;
      2: exp_led = 4'b0100;
      default: exp_led = 4'b1000;
    endcase
  endtask

  // Compare the DUT with the model after every rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk7("model_seg", seg, exp_seg);
      chk4("model_an", an, exp_an);
      chk4("model_sel_led", sel_led, exp_led);
    end
  end

  // ---------------------------------------------------------------- helpers
  logic [6:0] snapd [4];
  logic       snap_blank;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] want, input string nm);
    bit hit;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(posedge clk); #1;
      if (an === want) hit = 1;
    end
    if (!hit) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout, an=%b expected %b", nm, an, want);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) snapd[i] = 'x;
    snap_blank = 1'b0;
    for (int c = 0; c < 4 * REF; c++) begin
      @(posedge clk); #1;
      case (an)
        4'b1110: snapd[0] = seg;
        4'b1101: snapd[1] = seg;
        4'b1011: snapd[2] = seg;
        4'b0111: snapd[3] = seg;
        4'b1111: snap_blank = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic press(input int len);
    @(negedge clk);
    btn_next = 1'b1;
    cyc(len);
    btn_next = 1'b0;
    cyc(12);
  endtask

  task automatic rand_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: A0 = 8'($urandom);
          1: A1 = 8'($urandom);
          2: A2 = 8'($urandom);
          default: A3 = 8'($urandom);
        endcase
      end
    end
  endtask

  logic [3:0] wrap_seq [4];

  // ---------------------------------------------------------------- stimulus
  initial begin
    wrap_seq[0] = 4'b0010; wrap_seq[1] = 4'b0100;
    wrap_seq[2] = 4'b1000; wrap_seq[3] = 4'b0001;
    A0 = 8'h3C; A1 = 8'h12; A2 = 8'h07; A3 = 8'hA5;
    btn_next = 1'b0;
    rst_n = 1'b0;
    cyc(3);

    // Reset state
    @(posedge clk); #1;
    chk4("reset_an", an, 4'b1111);
    chk7("reset_seg", seg, 7'b1111111);
    chk4("reset_sel_led", sel_led, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk4("first_an", an, 4'b1110);
    chk7("first_seg", seg, 7'b1000000);

    // One frame later the display reads A 0 3 C
    cyc(16);
    snap();
    chk7("frame_dig3_A", snapd[3], 7'b0001000);
    chk7("frame_dig2_0", snapd[2], 7'b1000000);
    chk7("frame_dig1_3", snapd[1], 7'b0110000);
    chk7("frame_dig0_C", snapd[0], 7'b1000110);

    // Short glitch is rejected, a long press advances once
    press(3);
    @(posedge clk); #1;
    chk4("glitch_sel_led", sel_led, 4'b0001);
    press(10);
    @(posedge clk); #1;
    chk4("press_sel_led", sel_led, 4'b0010);

    // A1 changes while slot 1 is on screen
    cyc(10);
    wait_an(4'b1110, "mid_sync0");
    wait_an(4'b1101, "mid_sync1");
    @(negedge clk);
    A1 = 8'h34;
    @(posedge clk); #1;
    chk4("mid_old_an", an, 4'b1101);
    chk7("mid_old_hi", seg, 7'b1111001);
    wait_an(4'b1110, "mid_sync2");
    chk7("mid_new_lo", seg, 7'b0011001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk4("mid_new_an", an, 4'b1101);
    chk7("mid_new_hi", seg, 7'b0110000);

    // A2 = 0x07: leading-zero slot
    press(10);
    @(posedge clk); #1;
    chk4("sel2_sel_led", sel_led, 4'b0100);
    cyc(10);
    snap();
    chk7("lz_dig0_7", snapd[0], 7'b1111000);
`ifdef DISP_LZ_BLANK_EN
    chk1("lz_blanked", snap_blank, 1'b1);
`else
    chk1("lz_blanked", snap_blank, 1'b0);
    chk7("lz_dig1_0", snapd[1], 7'b1000000);
`endif

    // Return to sel 0, then four presses wrap all the way round
    press(10);
    @(posedge clk); #1;
    chk4("sel3_sel_led", sel_led, 4'b1000);
    press(10);
    @(posedge clk); #1;
    chk4("sel0_sel_led", sel_led, 4'b0001);
    for (int p = 0; p < 4; p++) begin
      press(10);
      @(posedge clk); #1;
      chk4("wrap_sel_led", sel_led, wrap_seq[p]);
    end

    // Asynchronous reset in the middle of slot 2, button held through release
    wait_an(4'b1011, "areset_sync");
    #2;
    rst_n = 1'b0;
    btn_next = 1'b1;
    #1;
    chk4("areset_an", an, 4'b1111);
    chk7("areset_seg", seg, 7'b1111111);
    chk4("areset_sel_led", sel_led, 4'b0001);
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    @(posedge clk); #1;
    chk4("held_sel_led", sel_led, 4'b0001);
    @(negedge clk);
    btn_next = 1'b0;
    cyc(12);
    press(10);
    @(posedge clk); #1;
    chk4("repress_sel_led", sel_led, 4'b0010);

    // Randomized presses, bounces and word changes, checked by the model
    @(negedge clk);
    repeat (120) begin
      btn_next = 1'b1;
      rand_cycles($urandom_range(1, 12));
      btn_next = 1'b0;
      rand_cycles($urandom_range(1, 14));
    end

    cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
